// File: rtl/pll_lock_supervisor_if.sv
// Bundle between the PLL lock supervisor and its PLL wrapper / status consumers.
interface pll_lock_supervisor_if #(
   parameter int unsigned NUM_DOMAINS = 5
);
   logic                   pll_locked;
   logic                   clear_fault;
   logic                   pll_rst;
   logic [NUM_DOMAINS-1:0] domain_rst;
   logic                   all_ready;
   logic                   fault;
   logic [2:0]             state;
   logic [2:0]             retry_count;
   logic [7:0]             loss_count;

   // Supervisor side
   modport master (
      input  pll_locked, clear_fault,
      output pll_rst, domain_rst, all_ready, fault, state, retry_count, loss_count
   );

   // PLL wrapper / status side
   modport slave (
      output pll_locked, clear_fault,
      input  pll_rst, domain_rst, all_ready, fault, state, retry_count, loss_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL reset, qualifies lock, releases domain
// resets in order, handles lock loss, timeouts, bounded retries and fault.
// Optional macro PLL_SUP_LOSS_COUNT_EN builds the saturating lock-loss counter;
// without it loss_count is tied to zero.
module pll_lock_supervisor #(
   parameter int unsigned NUM_DOMAINS    = 5,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 50000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned RELEASE_GAP    = 8,
   parameter int unsigned MAX_RETRY      = 3
) (
   input logic                   refclk,
   input logic                   rst,
   pll_lock_supervisor_if.master bus
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4,
      S_LOST      = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   localparam int unsigned CNT_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX = (CNT_A > STABLE_CYCLES) ? CNT_A : STABLE_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned GW      = $clog2(RELEASE_GAP + 1);
   localparam int unsigned RW      = $clog2(NUM_DOMAINS + 1);

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [RW-1:0]          rel_q, rel_d;
   logic [2:0]             retry_q, retry_d;
   logic                   pll_rst_q, pll_rst_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   all_ready_q, all_ready_d;
   logic                   fault_q, fault_d;
   logic [1:0]             sync_q;
   logic                   locked_s;

   assign locked_s = sync_q[1];

   // Two-flop synchroniser for the asynchronous PLL locked signal
   always_ff @(posedge refclk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], bus.pll_locked};
   end

   // State, counters and registered outputs
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         gap_q       <= '0;
         rel_q       <= '0;
         retry_q     <= 3'd0;
         pll_rst_q   <= 1'b1;
         dom_q       <= '1;
         all_ready_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         rel_q       <= rel_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         dom_q       <= dom_d;
         all_ready_q <= all_ready_d;
         fault_q     <= fault_d;
      end
   end

   // Next-state, counter updates and next output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      rel_d   = rel_q;
      retry_d = retry_q;

      unique case (state_q)
         S_PLL_RST: begin
            if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            // Lock takes priority over a timeout expiring in the same cycle
            if (locked_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               retry_d = retry_q + 3'd1;
               cnt_d   = '0;
               state_d = (retry_d == 3'(MAX_RETRY)) ? S_FAULT : S_PLL_RST;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               state_d = S_RELEASE;
               cnt_d   = '0;
               gap_d   = '0;
               rel_d   = RW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RELEASE: begin
            if (!locked_s) begin
               state_d = S_LOST;
            end else if (gap_q == GW'(RELEASE_GAP - 1)) begin
               gap_d = '0;
               if (rel_q == RW'(NUM_DOMAINS)) begin
                  state_d = S_RUN;
                  retry_d = 3'd0;
               end else begin
                  rel_d = rel_q + RW'(1);
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         S_RUN: begin
            if (!locked_s) state_d = S_LOST;
         end
         S_LOST: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
         S_FAULT: begin
            if (bus.clear_fault) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
               retry_d = 3'd0;
            end
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase

      pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
      all_ready_d = (state_d == S_RUN);
      fault_d     = (state_d == S_FAULT);
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
         if (state_d == S_RUN)          dom_d[i] = 1'b0;
         else if (state_d == S_RELEASE) dom_d[i] = (RW'(i) >= rel_d);
         else                           dom_d[i] = 1'b1;
      end
   end

   assign bus.pll_rst     = pll_rst_q;
   assign bus.domain_rst  = dom_q;
   assign bus.all_ready   = all_ready_q;
   assign bus.fault       = fault_q;
   assign bus.state       = state_q;
   assign bus.retry_count = retry_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
   logic [7:0] loss_q;
   logic       loss_evt;

   // LOST lasts one cycle, so any transition into it is a new loss event
   assign loss_evt = (state_d == S_LOST) && (state_q != S_LOST);

   // Saturating lock-loss counter, cleared only by reset
   always_ff @(posedge refclk) begin
      if (rst)                              loss_q <= 8'd0;
      else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
   end

   assign bus.loss_count = loss_q;
`else
   assign bus.loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a timeline reference model pushes
// the expected outputs of every edge; a monitor pops and compares after it.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

   localparam int ND   = 5;
   localparam int PRC  = 4;
   localparam int TO   = 20;
   localparam int SC   = 8;
   localparam int GAP  = 2;
   localparam int MAXR = 2;

   localparam int P_PLL_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3,
                  P_RUN = 4, P_LOST = 5, P_FAULT = 6;

   typedef struct packed {
      logic          pll_rst;
      logic [ND-1:0] domain_rst;
      logic          all_ready;
      logic          fault;
      logic [2:0]    state;
      logic [2:0]    retry_count;
      logic [7:0]    loss_count;
   } obs_t;

   logic refclk = 1'b0;
   logic rst    = 1'b1;

   pll_lock_supervisor_if #(.NUM_DOMAINS(ND)) bus ();

   pll_lock_supervisor #(
      .NUM_DOMAINS(ND), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO),
      .STABLE_CYCLES(SC), .RELEASE_GAP(GAP), .MAX_RETRY(MAXR)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus)
   );

   always #10 refclk = ~refclk;

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];
   obs_t last_exp;

   // Reference model: phase plus cycles elapsed in it, synchroniser as history
   int   m_phase, m_t, m_retry, m_loss;
   logic m_h0, m_h1;

   task automatic model_step(input logic r, input logic lk, input logic cf);
      logic ls;
      if (r) begin
         m_phase = P_PLL_RST; m_t = 0; m_retry = 0; m_loss = 0; m_h0 = 0; m_h1 = 0;
         return;
      end
      ls = m_h1; m_h1 = m_h0; m_h0 = lk;
      case (m_phase)
         P_PLL_RST: if (m_t + 1 == PRC) begin m_phase = P_WAIT; m_t = 0; end else m_t++;
         P_WAIT: begin
            if (ls) begin m_phase = P_STABLE; m_t = 0; end
            else if (m_t + 1 == TO) begin
               m_retry++;
               m_phase = (m_retry == MAXR) ? P_FAULT : P_PLL_RST;
               m_t = 0;
            end else m_t++;
         end
         P_STABLE: begin
            if (!ls) begin m_phase = P_WAIT; m_t = 0; end
            else if (m_t + 1 == SC) begin m_phase = P_RELEASE; m_t = 0; end
            else m_t++;
         end
         P_RELEASE: begin
            if (!ls) begin
               m_phase = P_LOST; m_t = 0;
`ifdef PLL_SUP_LOSS_COUNT_EN
               if (m_loss < 255) m_loss++;
`endif
            end else if (m_t + 1 == ND * GAP) begin m_phase = P_RUN; m_t = 0; m_retry = 0; end
            else m_t++;
         end
         P_RUN: if (!ls) begin
            m_phase = P_LOST; m_t = 0;
`ifdef PLL_SUP_LOSS_COUNT_EN
            if (m_loss < 255) m_loss++;
`endif
         end
         P_LOST:  begin m_phase = P_PLL_RST; m_t = 0; end
         P_FAULT: if (cf) begin m_phase = P_PLL_RST; m_t = 0; m_retry = 0; end
         default: begin m_phase = P_PLL_RST; m_t = 0; end
      endcase
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      int   released;
      o.pll_rst   = (m_phase == P_PLL_RST) || (m_phase == P_FAULT);
      o.all_ready = (m_phase == P_RUN);
      o.fault     = (m_phase == P_FAULT);
      if (m_phase == P_RUN) o.domain_rst = '0;
      else if (m_phase == P_RELEASE) begin
         released     = 1 + m_t / GAP;
         o.domain_rst = ND'(32'h1f << released);
      end else o.domain_rst = '1;
      o.state       = 3'(m_phase);
      o.retry_count = 3'(m_retry);
      o.loss_count  = 8'(m_loss);
      return o;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after its edge
   task automatic cyc(input logic r, input logic lk, input logic cf);
      @(negedge refclk);
      rst = r; bus.pll_locked = lk; bus.clear_fault = cf;
      model_step(r, lk, cf);
      last_exp = model_obs();
      exp_q.push_back(last_exp);
   endtask

   task automatic settle();
      @(posedge refclk); #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Monitor: compare the DUT outputs after every edge that has an expectation
   int   mon_cyc = 0;
   obs_t mon_exp, mon_got;
   initial forever begin
      @(posedge refclk); #1;
      mon_cyc++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {bus.pll_rst, bus.domain_rst, bus.all_ready, bus.fault,
                    bus.state, bus.retry_count, bus.loss_count};
         n_checks++;
         if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL outputs cycle=%0d got rst=%b dom=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d required rst=%b dom=%b rdy=%b flt=%b st=%0d rty=%0d loss=%0d",
                     mon_cyc, mon_got.pll_rst, mon_got.domain_rst, mon_got.all_ready, mon_got.fault,
                     mon_got.state, mon_got.retry_count, mon_got.loss_count,
                     mon_exp.pll_rst, mon_exp.domain_rst, mon_exp.all_ready, mon_exp.fault,
                     mon_exp.state, mon_exp.retry_count, mon_exp.loss_count);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.pll_locked  = 1'b0;
      bus.clear_fault = 1'b0;

      // Reset values
      cyc(1, 0, 0); settle();
      check("reset_pll_rst", int'(bus.pll_rst), 1);
      check("reset_domain_rst", int'(bus.domain_rst), 31);
      check("reset_state", int'(bus.state), 0);
      cyc(1, 0, 0);

      // Nominal bring-up: pll_rst high exactly 4 cycles after reset release
      for (int i = 0; i < PRC; i++) begin
         cyc(0, 0, 0); settle();
         check("pll_rst_pulse", int'(bus.pll_rst), (i < PRC - 1) ? 1 : 0);
      end
      repeat (2) cyc(0, 0, 0);
      repeat (40) cyc(0, 1, 0);
      settle();
      check("nominal_state", int'(bus.state), 4);
      check("nominal_all_ready", int'(bus.all_ready), 1);
      check("nominal_domain_rst", int'(bus.domain_rst), 0);

      // Lock loss in RUN: LOST on the third edge after the drop, pll_rst one later
      cyc(0, 0, 0); settle(); check("loss_ready_e0", int'(bus.all_ready), 1);
      cyc(0, 0, 0); settle(); check("loss_ready_e1", int'(bus.all_ready), 1);
      cyc(0, 0, 0); settle();
      check("loss_ready_e2", int'(bus.all_ready), 0);
      check("loss_domain_e2", int'(bus.domain_rst), 31);
      check("loss_pll_rst_e2", int'(bus.pll_rst), 0);
      cyc(0, 0, 0); settle();
      check("loss_pll_rst_e3", int'(bus.pll_rst), 1);
`ifdef PLL_SUP_LOSS_COUNT_EN
      check("loss_count_one", int'(bus.loss_count), 1);
`else
      check("loss_count_off", int'(bus.loss_count), 0);
`endif

      // Mid-release loss: drop lock when the model shows 11100
      for (int i = 0; i < 100; i++) begin
         cyc(0, 1, 0);
         if (last_exp.domain_rst == 5'b11100) break;
      end
      cyc(0, 0, 0); settle();
      cyc(0, 0, 0); settle();
      cyc(0, 1, 0); settle();
      check("midrel_state", int'(bus.state), 5);
      check("midrel_domain", int'(bus.domain_rst), 31);
      repeat (40) cyc(0, 1, 0);
      settle();
      check("midrel_rerun_state", int'(bus.state), 4);

      // Glitch in STABLE restarts qualification without a retry
      repeat (2) cyc(1, 0, 0);
      repeat (5) cyc(0, 0, 0);
      repeat (5) cyc(0, 1, 0);
      cyc(0, 0, 0);
      repeat (40) cyc(0, 1, 0);
      settle();
      check("glitch_state", int'(bus.state), 4);
      check("glitch_retry", int'(bus.retry_count), 0);

      // Timeout to fault, then clear
      repeat (2) cyc(1, 0, 0);
      for (int i = 0; i < 60; i++) begin
         cyc(0, 0, 0); settle();
         if (i == 23) check("timeout_retry1", int'(bus.retry_count), 1);
         if (i == 59) begin
            check("fault_state", int'(bus.state), 6);
            check("fault_flag", int'(bus.fault), 1);
            check("fault_pll_rst", int'(bus.pll_rst), 1);
            check("fault_retry2", int'(bus.retry_count), 2);
         end
      end
      cyc(0, 1, 0); settle();
      check("fault_holds", int'(bus.state), 6);
      cyc(0, 0, 1); settle();
      check("clear_state", int'(bus.state), 0);
      check("clear_retry", int'(bus.retry_count), 0);

      // Randomised lock behaviour with sporadic clears and resets
      for (int ep = 0; ep < 6; ep++) begin
         logic lvl;
         int   run;
         lvl = 1'b0; run = 0;
         for (int i = 0; i < 300; i++) begin
            if (run == 0) begin
               lvl = ~lvl;
               run = lvl ? int'($urandom_range(45, 1)) : int'($urandom_range(30, 1));
            end
            run--;
            cyc(($urandom_range(399, 0) == 0), lvl, ($urandom_range(24, 0) == 0));
         end
         if (n_fail > 40) break;
      end

      // Saturation: 260 lock-loss events after a fresh reset
      cyc(1, 0, 0);
      for (int k = 0; k < 260; k++) begin
         repeat (30) cyc(0, 1, 0);
         repeat (2) cyc(0, 0, 0);
         if (n_fail > 40) break;
      end
      repeat (5) cyc(0, 1, 0);
      settle();
`ifdef PLL_SUP_LOSS_COUNT_EN
      check("loss_saturated", int'(bus.loss_count), 255);
`else
      check("loss_tied_zero", int'(bus.loss_count), 0);
`endif

      // Reset mid-operation clears everything including the loss counter
      cyc(1, 1, 0); settle();
      check("rst_loss", int'(bus.loss_count), 0);
      check("rst_state", int'(bus.state), 0);
      check("rst_pll_rst", int'(bus.pll_rst), 1);

      repeat (3) @(posedge refclk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the five-output fabric PLL and the clock domains it feeds. Drives the PLL reset, waits for and qualifies `locked`, then releases per-domain resets one at a time in a fixed order. Detects lock loss and PLL lock timeouts, retries a bounded number of times, and latches a fault. Sits in the `refclk` domain between the board reset and the PLL wrapper. Downstream re-synchronisation of each `domain_rst` bit into its own output clock is done by the consuming domain, not here.

## Interface
- `NUM_DOMAINS`, 5: number of sequenced domain resets, one per PLL output; legal range 1–8.
- `PLL_RST_CYCLES`, 16: `pll_rst` pulse length, in `refclk` cycles; at least 1.
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry is declared.
- `STABLE_CYCLES`, 1024: consecutive synchronised-high `locked` samples required before release starts.
- `RELEASE_GAP`, 8: cycles between successive domain releases; at least 1.
- `MAX_RETRY`, 3: timeouts tolerated before entering FAULT; at least 1.
- `refclk`  in  1: PLL reference clock, 50 MHz. This is the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `pll_locked`  in  1: PLL `locked`. It is asynchronous, so it passes through a 2-flop synchroniser (`locked_s`).
- `clear_fault`  in  1: single-cycle pulse that exits FAULT.
- `pll_rst`  out  1: drives the PLL `rst`.
- `domain_rst`  out  NUM_DOMAINS: per-domain reset, active-high; bit 0 is released first.
- `all_ready`  out  1: high only in RUN.
- `fault`  out  1: high only in FAULT.
- `state`  out  3: current FSM state code.
- `retry_count`  out  3: number of timeouts since the last RUN or clear.
- `loss_count`  out  8: lock-loss event counter; see Configuration.

## Operation
- State codes: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, LOST=5, FAULT=6.
- **PLL_RST**
  - `pll_rst`=1 and all `domain_rst`=1.
  - After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_rst`=0 and a timeout counter runs.
  - `locked_s`=1 → STABLE.
  - Counter reaches `LOCK_TIMEOUT`: `retry_count`++. Then go to FAULT if `retry_count` now equals `MAX_RETRY`, otherwise go to PLL_RST.
- **STABLE**
  - A counter counts consecutive `locked_s`=1 samples.
  - Any `locked_s`=0 → WAIT_LOCK with the timeout counter cleared and no retry increment.
  - Count reaches `STABLE_CYCLES` → RELEASE.
- **RELEASE**
  - `domain_rst[0]` clears on entry.
  - Each following `domain_rst[i]` clears `RELEASE_GAP` cycles after `domain_rst[i-1]`.
  - `RELEASE_GAP` cycles after the last bit clears → RUN.
- **RUN**
  - `all_ready`=1 and `retry_count` clears.
- **LOST**
  - Entered from RELEASE or RUN when `locked_s`=0.
  - All `domain_rst`=1, `all_ready`=0, `loss_count`++.
  - After one cycle → PLL_RST.
- **FAULT**
  - `pll_rst`=1, all `domain_rst`=1, `fault`=1.
  - `clear_fault` → PLL_RST with `retry_count`=0.
  - `clear_fault` has no effect in any other state.
- Counter widths are sized by `$clog2` of their terminal value. No counter wraps: each one is cleared on state entry.

## Timing
- **Reset values:** `pll_rst`=1, `domain_rst`=all 1, `all_ready`=0, `fault`=0, `state`=0, `retry_count`=0, `loss_count`=0, synchroniser flops=0.
- All outputs are registered and change on the edge that enters the new state.
- **Reset and clear:**
  - After `rst` falls, `pll_rst` stays 1 for exactly `PLL_RST_CYCLES` cycles.
  - `rst` dominates `clear_fault` and every other condition.
- **Synchroniser latency:** `pll_locked` edge to `locked_s` is 2 cycles.
- **Lock-loss response:**
  - From `locked_s` falling in RUN: `all_ready`=0 and all `domain_rst`=1 on the next edge (LOST entry).
  - `pll_rst` rises one cycle later.
- **Simultaneous events:**
  - In WAIT_LOCK, `locked_s`=1 in the same cycle the timeout expires: lock wins and no retry is counted.
  - Lock loss during RELEASE: domains already released are re-asserted together; no partial release remains.
- **Reset mid-operation:** an `rst` pulse in any state returns all outputs to reset values on the next edge, including FAULT and `loss_count`.

## Configuration
- `PLL_SUP_LOSS_COUNT_EN` defined: `loss_count` is an 8-bit saturating counter (holds at 255). It increments once per LOST entry and clears only on `rst`.
- Not defined: the counter is not built and `loss_count` is tied to 0.

## Test plan
Bench parameters: `NUM_DOMAINS`=5, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `RELEASE_GAP`=2, `MAX_RETRY`=2.
- **Nominal bring-up:**
  - Stimulus: release `rst`, raise `pll_locked` 3 cycles after `pll_rst` falls.
  - Response: `pll_rst` high 4 cycles. `domain_rst` steps 11111→11110→11100→11000→10000→00000 at 2-cycle spacing. `all_ready`=1 2 cycles after the last step, `state`=4.
- **Glitch in STABLE:**
  - Stimulus: `locked` high for 5 cycles, low 1 cycle, then high.
  - Response: STABLE restarts via WAIT_LOCK, release is delayed by the full 8-cycle qualification, `retry_count`=0.
- **Timeout to fault:**
  - Stimulus: hold `pll_locked`=0.
  - Response: two 20-cycle WAIT_LOCK windows, `retry_count` 1 then 2, `state`=6, `fault`=1, `pll_rst`=1.
  - Then pulse `clear_fault`: `state`=0 and `retry_count`=0.
- **Lock loss in RUN:**
  - Stimulus: drop `pll_locked` in RUN.
  - Response: 2 cycles later `all_ready`=0 and `domain_rst`=11111. `pll_rst`=1 on the following cycle. With the macro defined, `loss_count`=1.
- **Mid-release loss:**
  - Stimulus: drop `pll_locked` when `domain_rst`=11100.
  - Response: `domain_rst`=11111 on LOST entry, then a full re-sequence.
- **Saturation (macro defined):**
  - Stimulus: 260 lock-loss events.
  - Response: `loss_count`=255.
